// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches to instruction memory,
// buffers returned words with their PCs in a prefetch FIFO, and hands them to
// decode over a valid/ready handshake. Redirects flush buffered words and drop
// responses to fetches that were already in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          accept;
  logic          rsp_fire;
  logic          drop_rsp;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_next;
  logic [31:0]   redirect_aligned;

  // Credit covers both buffered words and requests still in flight, so a
  // returning response always finds a free FIFO slot.
  always_comb begin
    credit_used    = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = credit_used < (CW+1)'(FIFO_DEPTH);
    imem_req_addr  = fetch_pc;
  end

  // Handshake events and the in-flight count seen after this cycle.
  always_comb begin
    accept           = imem_req_valid & imem_req_ready;
    rsp_fire         = imem_rsp_valid & (outstanding != '0);
    drop_rsp         = drop_cnt != '0;
    push             = rsp_fire & ~drop_rsp & ~redirect_valid;
    pop              = instr_valid & instr_ready;
    outstanding_next = outstanding + CW'(accept) - CW'(rsp_fire);
    redirect_aligned = {redirect_pc[31:2], 2'b00};
  end

  // FIFO head to decode; outputs read zero while the buffer is empty.
  always_comb begin
    instr_valid = count != '0;
    instr_out   = instr_valid ? instr_mem[rd_ptr] : '0;
    instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;
  end

  // Fetch/response PCs, in-flight tracking, drop counter and FIFO pointers.
  // On redirect every request still unanswered (including one accepted this
  // very cycle at the old address) becomes a response to discard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      outstanding <= outstanding_next;
      drop_cnt    <= outstanding_next;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding_next;
      if (rsp_fire && drop_rsp) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only observable through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
